// File: rtl/uart_frame_led_ctrl.sv
// -----------------------------------------------------------------------------
// uart_frame_led_ctrl
//   Multi-channel LED sequencer programmed over a UART RX line.
//   An 8N1 receiver feeds a framed-command parser. Each accepted frame loads
//   a step time and an 8-bit pattern into one channel. Each channel then shifts
//   its pattern out on its LED and holds every bit for `time` prescaler ticks.
//   Frame layout: 55 A5 CH T3 T2 T1 T0 PAT F0 (T is big-endian).
//
// Ports
//   Clk        in   1        system clock, rising edge
//   Reset      in   1        asynchronous, active-high reset
//   uart_rx    in   1        asynchronous UART line, idle high
//   led        out  LED_NUM  LED drive, 1 = on
//   frame_ok   out  1        one-cycle pulse: valid frame committed
//   frame_err  out  1        one-cycle pulse: frame rejected
// -----------------------------------------------------------------------------
module uart_frame_led_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int LED_NUM      = 4,
  parameter int PATTERN_W    = 8,
  parameter int TIME_W       = 32,
  parameter int TICK_DIV     = 50_000,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               uart_rx,
  output logic [LED_NUM-1:0] led,
  output logic               frame_ok,
  output logic               frame_err
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int CYC_W    = $clog2(BIT_CYC + 1);
  localparam int TO_LIMIT = TIMEOUT_BITS * BIT_CYC;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int TICK_W   = $clog2(TICK_DIV + 1);
  localparam int STEP_W   = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

  localparam logic [CYC_W-1:0]  HALF_CYC  = CYC_W'(BIT_CYC / 2);
  localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(BIT_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PATTERN_W - 1);

  // ---------------------------------------------------------------------------
  // UART receiver (8N1)
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t         rx_state_q;
  logic              rx_meta_q;
  logic              rx_sync_q;
  logic              rx_prev_q;
  logic [CYC_W-1:0]  rx_cyc_q;
  logic [2:0]        rx_bit_q;
  logic [7:0]        rx_shift_q;
  logic [7:0]        rx_data_q;
  logic              rx_done_q;
  logic              stop_err_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_state_q <= RX_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cyc_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_done_q  <= 1'b0;
      stop_err_q <= 1'b0;

      case (rx_state_q)
        RX_IDLE: begin
          // Falling edge of the synchronised line marks a start bit.
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cyc_q   <= '0;
          end
        end

        RX_START: begin
          // Mid-bit check filters glitches shorter than half a bit.
          if (rx_cyc_q == HALF_CYC) begin
            rx_cyc_q <= '0;
            rx_bit_q <= '0;
            if (rx_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
            end
          end else begin
            rx_cyc_q <= rx_cyc_q + 1'b1;
          end
        end

        RX_DATA: begin
          if (rx_cyc_q == LAST_CYC) begin
            rx_cyc_q   <= '0;
            // LSB arrives first, so shift in from the top.
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end else begin
            rx_cyc_q <= rx_cyc_q + 1'b1;
          end
        end

        RX_STOP: begin
          if (rx_cyc_q == LAST_CYC) begin
            rx_cyc_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              rx_done_q <= 1'b1;
              rx_data_q <= rx_shift_q;
            end else begin
              stop_err_q <= 1'b1;
            end
          end else begin
            rx_cyc_q <= rx_cyc_q + 1'b1;
          end
        end

        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    P_HDR0,
    P_HDR1,
    P_CH,
    P_T3,
    P_T2,
    P_T1,
    P_T0,
    P_PAT,
    P_TAIL
  } p_state_t;

  p_state_t          p_state_q;
  logic [7:0]        sh_ch_q;
  logic [31:0]       sh_time_q;
  logic [7:0]        sh_pat_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              frame_ok_q;
  logic              frame_err_q;
  logic              commit;

  // Channel registers load on the same edge that raises frame_ok.
  assign commit = rx_done_q && (p_state_q == P_TAIL) && (rx_data_q == 8'hF0) &&
                  (int'(sh_ch_q) < LED_NUM);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p_state_q   <= P_HDR0;
      sh_ch_q     <= '0;
      sh_time_q   <= '0;
      sh_pat_q    <= '0;
      to_cnt_q    <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (stop_err_q) begin
        frame_err_q <= 1'b1;
        p_state_q   <= P_HDR0;
        to_cnt_q    <= '0;
      end else if (rx_done_q) begin
        to_cnt_q <= '0;
        case (p_state_q)
          P_HDR0: if (rx_data_q == 8'h55) p_state_q <= P_HDR1;
          P_HDR1: begin
            // A repeated 55 may be the real start of the header.
            if (rx_data_q == 8'hA5) begin
              p_state_q <= P_CH;
            end else if (rx_data_q != 8'h55) begin
              p_state_q <= P_HDR0;
            end
          end
          P_CH: begin
            sh_ch_q   <= rx_data_q;
            p_state_q <= P_T3;
          end
          P_T3: begin
            sh_time_q <= {sh_time_q[23:0], rx_data_q};
            p_state_q <= P_T2;
          end
          P_T2: begin
            sh_time_q <= {sh_time_q[23:0], rx_data_q};
            p_state_q <= P_T1;
          end
          P_T1: begin
            sh_time_q <= {sh_time_q[23:0], rx_data_q};
            p_state_q <= P_T0;
          end
          P_T0: begin
            sh_time_q <= {sh_time_q[23:0], rx_data_q};
            p_state_q <= P_PAT;
          end
          P_PAT: begin
            sh_pat_q  <= rx_data_q;
            p_state_q <= P_TAIL;
          end
          P_TAIL: begin
            if (commit) begin
              frame_ok_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            p_state_q <= P_HDR0;
          end
          default: p_state_q <= P_HDR0;
        endcase
      end else if (p_state_q != P_HDR0) begin
        // Inter-byte watchdog; shadows are simply overwritten by the next frame.
        if (to_cnt_q == TO_LAST) begin
          to_cnt_q  <= '0;
          p_state_q <= P_HDR0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------
  // Shared time-unit prescaler
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (tick) tick_cnt_d = '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel pattern sequencers
  // ---------------------------------------------------------------------------
  logic [LED_NUM-1:0] led_q;

  generate
    for (genvar gi = 0; gi < LED_NUM; gi++) begin : g_chan
      logic [TIME_W-1:0]    time_q;
      logic [TIME_W-1:0]    unit_q;
      logic [PATTERN_W-1:0] pat_q;
      logic [STEP_W-1:0]    step_q;
      logic                 load;

      assign load = commit && (sh_ch_q == 8'(gi));

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          time_q   <= '0;
          unit_q   <= '0;
          pat_q    <= '0;
          step_q   <= '0;
          led_q[gi] <= 1'b0;
        end else begin
          if (load) begin
            time_q <= TIME_W'(sh_time_q);
            pat_q  <= PATTERN_W'(sh_pat_q);
            unit_q <= '0;
            step_q <= '0;
          end else if (time_q == '0) begin
            unit_q <= '0;
            step_q <= '0;
          end else if (tick) begin
            if (unit_q == time_q - TIME_W'(1)) begin
              unit_q <= '0;
              step_q <= (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
            end else begin
              unit_q <= unit_q + 1'b1;
            end
          end
          // A zero step time parks the channel dark.
          led_q[gi] <= (time_q != '0) ? pat_q[step_q] : 1'b0;
        end
      end
    end
  endgenerate

  assign led = led_q;

endmodule

// File: tb/tb_uart_frame_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_led_ctrl
//   Scoreboarded bench: the stimulus process pushes the expected frame outcome
//   before sending each frame; a monitor pops on every frame_ok / frame_err
//   pulse and also compares the LED bank each cycle against a reference model
//   that computes the current step from elapsed prescaler ticks.
// -----------------------------------------------------------------------------
module tb_uart_frame_led_ctrl;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 3_125_000;          // 16 clocks per bit
  localparam int BC       = CLK_FREQ / BAUD;
  localparam int LED_NUM  = 4;
  localparam int TD       = 10;                 // clocks per time unit
  localparam int TO_BITS  = 20;

  logic               Clk;
  logic               Reset;
  logic               uart_rx;
  logic [LED_NUM-1:0] led;
  logic               frame_ok;
  logic               frame_err;

  uart_frame_led_ctrl #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .LED_NUM     (LED_NUM),
    .PATTERN_W   (8),
    .TIME_W      (32),
    .TICK_DIV    (TD),
    .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .uart_rx  (uart_rx),
    .led      (led),
    .frame_ok (frame_ok),
    .frame_err(frame_err)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit       ok;
    int       ch;
    int       t;
    bit [7:0] pat;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: per channel step time, pattern and commit edge.
  int       m_time [LED_NUM];
  bit [7:0] m_pat  [LED_NUM];
  longint   m_c    [LED_NUM];
  longint   edge_cnt;

  // Rising edges since reset release; prescaler ticks land on multiples of TD.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [LED_NUM-1:0] model_led(input longint n);
    logic [LED_NUM-1:0] r;
    longint ticks;
    int     step;
    r = '0;
    for (int ch = 0; ch < LED_NUM; ch++) begin
      if (m_time[ch] != 0) begin
        ticks = (n - 1) / TD - m_c[ch] / TD;
        step  = int'((ticks / m_time[ch]) % 8);
        r[ch] = m_pat[ch][step];
      end
    end
    return r;
  endfunction

  // Monitor / scoreboard consumer.
  initial begin : monitor
    logic [LED_NUM-1:0] exp_led;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        for (int ch = 0; ch < LED_NUM; ch++) begin
          m_time[ch] = 0;
          m_pat[ch]  = '0;
          m_c[ch]    = 0;
        end
      end else begin
        exp_led = model_led(edge_cnt);
        checks++;
        if (led !== exp_led) begin
          failures++;
          $display("FAIL led t=%0t got=%b exp=%b", $time, led, exp_led);
        end
        if (frame_ok || frame_err) begin
          checks++;
          if (frame_ok && frame_err) begin
            failures++;
            $display("FAIL pulse_both t=%0t ok=%b err=%b exp=exclusive", $time, frame_ok, frame_err);
          end else if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse t=%0t ok=%b err=%b exp=none", $time, frame_ok, frame_err);
          end else begin
            e = sb_q.pop_front();
            if (frame_ok != e.ok) begin
              failures++;
              $display("FAIL frame_result t=%0t got_ok=%b exp_ok=%b ch=%0d", $time, frame_ok, e.ok, e.ch);
            end else begin
              $display("frame t=%0t ok=%b ch=%0d time=%0d pat=%02h", $time, e.ok, e.ch, e.t, e.pat);
              if (e.ok) begin
                m_time[e.ch] = e.t;
                m_pat[e.ch]  = e.pat;
                m_c[e.ch]    = edge_cnt;
              end
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input bit stop);
    uart_rx = 1'b0;
    repeat (BC) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BC) @(negedge Clk);
    end
    uart_rx = stop;
    repeat (BC) @(negedge Clk);
    uart_rx = 1'b1;
    if (!stop) repeat (BC) @(negedge Clk);
    repeat (2) @(negedge Clk);
  endtask

  task automatic send_frame(input int ch, input int t, input logic [7:0] pat,
                            input logic [7:0] tail);
    exp_t e;
    logic [31:0] tv;
    e.ok  = (tail == 8'hF0) && (ch < LED_NUM);
    e.ch  = ch;
    e.t   = t;
    e.pat = pat;
    sb_q.push_back(e);
    tv = t;
    send_byte(8'h55, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'(ch), 1'b1);
    send_byte(tv[31:24], 1'b1);
    send_byte(tv[23:16], 1'b1);
    send_byte(tv[15:8], 1'b1);
    send_byte(tv[7:0], 1'b1);
    send_byte(pat, 1'b1);
    send_byte(tail, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_no_pulse pending=%0d exp=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int       ch;
    int       t;
    logic [7:0] pat;
    logic [7:0] tail;

    uart_rx = 1'b1;
    Reset   = 1'b1;
    idle(5);
    @(posedge Clk); #3 Reset = 1'b0;
    idle(50);

    // Directed: basic frame on channel 0.
    send_frame(0, 5, 8'h9A, 8'hF0);   wait_drain("t1");   idle(200);
    // Bad tail and out-of-range channel.
    send_frame(1, 10, 8'hFF, 8'hF1);  wait_drain("t2");
    send_frame(5, 10, 8'hFF, 8'hF0);  wait_drain("t3");
    // Repeated 55 before A5.
    send_byte(8'h55, 1'b1);
    send_frame(2, 4, 8'h0F, 8'hF0);   wait_drain("t4");   idle(100);
    // Partial frame abandoned by timeout, then T=0 frame for channel 3.
    send_byte(8'h55, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    idle(TO_BITS * BC + 80);
    send_frame(3, 0, 8'hAA, 8'hF0);   wait_drain("t5");
    // Stop-bit error in the middle of a frame.
    begin
      exp_t e;
      e.ok = 1'b0; e.ch = 2; e.t = 0; e.pat = 8'h00;
      sb_q.push_back(e);
      send_byte(8'h55, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h3C, 1'b0);
      wait_drain("t6_stop");
    end
    // Reset asserted while the fourth byte is on the line.
    send_byte(8'h55, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    uart_rx = 1'b0;
    idle(3 * BC);
    @(posedge Clk); #3 Reset = 1'b1;
    uart_rx = 1'b1;
    idle(5);
    @(posedge Clk); #3 Reset = 1'b0;
    idle(40);
    send_frame(1, 3, 8'hC5, 8'hF0);   wait_drain("t6_rst"); idle(150);

    // Randomized frames.
    for (int k = 0; k < 16; k++) begin
      ch  = $urandom_range(0, 5);
      t   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 7);
      pat = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        tail = 8'($urandom_range(0, 255));
        if (tail == 8'hF0) tail = 8'hF1;
      end else begin
        tail = 8'hF0;
      end
      send_frame(ch, t, pat, tail);
      wait_drain("rand");
      idle($urandom_range(0, 200));
    end

    idle(300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
